// File: rtl/alu_seq.sv
// Registered N-bit ALU with valid/ready handshakes, status flags and a
// multi-cycle unsigned shift-add multiplier; one operation in flight at a time.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               overflow,
  output logic               zero,
  output logic               negative
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [WIDTH-1:0]  mcand, mcand_d;
  logic [RW-1:0]     prod, prod_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [RW-1:0]     result_d;
  logic              carry_d, overflow_d, zero_d, negative_d;
  logic              in_ready_d, out_valid_d;

  logic [WIDTH:0]    sum_w, diff_w;
  logic [WIDTH-1:0]  alu_lo;
  logic              alu_c, alu_v;

  logic [WIDTH:0]    mul_sum;
  logic [RW-1:0]     prod_step;

  // Single-cycle ops, evaluated directly on the presented operands
  always_comb begin
    sum_w  = {1'b0, a} + {1'b0, b};
    diff_w = {1'b0, a} - {1'b0, b};
    alu_lo = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (op)
      OP_AND: alu_lo = a & b;
      OP_OR:  alu_lo = a | b;
      OP_XOR: alu_lo = a ^ b;
      OP_ADD: begin
        alu_lo = sum_w[WIDTH-1:0];
        alu_c  = sum_w[WIDTH];
        alu_v  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_lo = diff_w[WIDTH-1:0];
        alu_c  = diff_w[WIDTH];
        alu_v  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: alu_lo = a << b[SHW-1:0];
      OP_SHR: alu_lo = a >> b[SHW-1:0];
      default: alu_lo = '0;
    endcase
  end

  // One multiplier bit per cycle: conditionally add into the upper half, then shift right
  assign mul_sum   = {1'b0, prod[RW-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_step = {mul_sum, prod[WIDTH-1:1]};

  always_comb begin
    state_d     = state;
    mcand_d     = mcand;
    prod_d      = prod;
    cnt_d       = cnt;
    result_d    = result;
    carry_d     = carry;
    overflow_d  = overflow;
    zero_d      = zero;
    negative_d  = negative;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          in_ready_d = 1'b0;
          if (op == OP_MUL) begin
            state_d = BUSY;
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = '0;
          end else begin
            state_d     = DONE;
            result_d    = {{WIDTH{1'b0}}, alu_lo};
            carry_d     = alu_c;
            overflow_d  = alu_v;
            zero_d      = (alu_lo == '0);
            negative_d  = alu_lo[WIDTH-1];
            out_valid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        prod_d = prod_step;
        cnt_d  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          result_d    = prod_step;
          carry_d     = 1'b0;
          overflow_d  = 1'b0;
          zero_d      = (prod_step == '0);
          negative_d  = prod_step[RW-1];
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      mcand     <= mcand_d;
      prod      <= prod_d;
      cnt       <= cnt_d;
      result    <= result_d;
      carry     <= carry_d;
      overflow  <= overflow_d;
      zero      <= zero_d;
      negative  <= negative_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered N-bit ALU; successor to the single-bit combinational ALU.
- Adds width generalisation, extra ops, status flags, and a multi-cycle shift-add multiplier.
- Uses valid/ready handshakes on both sides.
- Sits between an operand/op issue stage and a result consumer; processes one operation at a time.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32).
SHW, $clog2(WIDTH), number of low bits of b used as the shift amount (derived; do not override).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand/op presented
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  2*WIDTH  result; upper WIDTH bits are zero except for MUL
carry  output  1  carry/borrow flag
overflow  output  1  signed overflow flag
zero  output  1  result == 0 (all 2*WIDTH bits)
negative  output  1  MSB of the significant result

Behaviour:
- Reset: only clk and rst are named for timing; reset is synchronous and active-high.
- Reset state: state=IDLE, in_ready=1, out_valid=0, result=0, carry=overflow=zero=negative=0.
- Reset while BUSY or DONE aborts the operation and discards the result.
- States:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready, latching a, b and op.
    - If op!=111, go to DONE with result/flags registered on the accepting edge (latency 1).
    - If op==111, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Performs unsigned shift-add, one bit of b per cycle, for exactly WIDTH cycles under an internal counter, then goes to DONE. Latency from the accepting edge to out_valid=1 is WIDTH+1 edges.
  - DONE: out_valid=1, in_ready=0. result and flags are held stable. On out_ready=1, go to IDLE and clear out_valid on that edge. result and flags hold their last value.
- Sustained throughput: one op per 2 cycles for non-MUL ops; no new op is accepted in the same cycle as the output handshake.
- in_valid while in_ready=0 is ignored; the source must hold it.
- Inputs a, b and op are sampled only on acceptance and may change afterwards.
- Op encoding (N = WIDTH):
  - 000 AND.
  - 001 OR.
  - 010 XOR.
  - 011 ADD: carry = carry-out of bit N-1; overflow = signed overflow.
  - 100 SUB (a-b): carry = borrow, i.e. a<b unsigned; overflow = signed overflow.
  - 101 SHL: logical shift of a by b[SHW-1:0].
  - 110 SHR: logical shift of a by b[SHW-1:0].
  - 111 MUL: unsigned a*b into the full 2N bits.
- Flags:
  - carry and overflow are 0 for every op other than ADD/SUB.
  - negative = result[N-1] for ops 000-110 and result[2N-1] for MUL.
  - zero is evaluated on all 2N bits.
- Wrap-around: ADD/SUB results are modulo 2^N; upper N result bits are 0.
- Shifts: shift amount 0 returns a unchanged. Bits of b above SHW are ignored.

Test Plan:
- WIDTH=8, op=011, a=0xFF, b=0x01 -> one edge after accept: result=0x0000, carry=1, zero=1, overflow=0, negative=0, out_valid=1.
- op=100, a=0x80, b=0x01 -> result=0x007F, overflow=1, carry=0, negative=0. Then a=0x01, b=0x02 -> result=0x00FF, carry=1, negative=1.
- op=111, a=0xFF, b=0xFF -> in_ready=0 for 9 cycles; out_valid rises exactly 9 edges after accept; result=0xFE01, negative=1, carry=0. Also a=0x00 -> zero=1.
- Backpressure: complete an op=001 with out_ready=0 for 5 cycles -> out_valid, result and flags stable and in_ready=0 throughout. Then out_ready=1 for 1 cycle -> out_valid=0 and in_ready=1 next cycle; a held in_valid is accepted then.
- op=101, a=0x81, b=0x09 -> shift by 1: result=0x0002, carry=0. op=110, a=0x81, b=0x00 -> result=0x0081, negative=1.
- Assert rst during BUSY at cycle 4 of a MUL -> next edge: in_ready=1, out_valid=0, all outputs 0. A subsequent ADD 0x02+0x03 returns 0x0005 normally.
